wb_traffic_gen: RTL and testbench

Self-checking Wishbone B3 classic/burst master that generates pseudo-random write bursts, reads each burst back, and compares the returned data. It provides stimulus for one port of the multi-port DDR Wishbone controller, one instance per port, each confined to its own address window. It counts completed work, flags any mismatch or bus error, and raises `done` when its quota is finished.

---
 rtl/wb_traffic_gen_pkg.sv | 23 ++
 rtl/wb_traffic_gen_lfsr32.sv | 22 ++
 rtl/wb_traffic_gen.sv | 153 +++++++++++++++
 tb/tb_wb_traffic_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_traffic_gen_pkg.sv
// Shared constants, FSM encoding and the LFSR step for the Wishbone traffic generator.
package wb_traffic_gen_pkg;

  localparam logic [2:0]  CTI_INC   = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Galois step: shift right, fold the polynomial in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/wb_traffic_gen_lfsr32.sv
// 32-bit Galois LFSR with parallel load and step enable; reset value is SEED.
module lfsr32
  import wb_traffic_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  // Load wins over step so a restore and a step never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (load) state <= load_val;
    else if (en)   state <= lfsr_step(state);
  end

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone burst master: writes a pseudo-random burst, reads it back and checks it,
// repeating TRANSACTIONS*SUBTRANSACTIONS times inside [MEM_LOW, MEM_HIGH].
module wb_traffic_gen
  import wb_traffic_gen_pkg::*;
#(
  parameter logic [31:0] MEM_LOW         = 32'h0000_0000,
  parameter logic [31:0] MEM_HIGH        = 32'h000F_FFFF,
  parameter int unsigned TRANSACTIONS    = 10,
  parameter int unsigned SUBTRANSACTIONS = 10,
  parameter logic [31:0] SEED            = 32'h0000_0001,
  parameter bit          VERBOSE         = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        done,
  output logic        err
);

  localparam logic [32:0] WIN_BYTES = {1'b0, MEM_HIGH} - {1'b0, MEM_LOW} + 33'd1;
  localparam logic [31:0] WORDS     = {1'b0, WIN_BYTES[32:2]};
  localparam logic [31:0] SUB_LAST  = 32'(SUBTRANSACTIONS - 1);
  localparam logic [31:0] TXN_LAST  = 32'(TRANSACTIONS - 1);

  state_t      state, nstate;
  logic        started;
  logic [2:0]  beat, len_m1;
  logic [31:0] base, dat_save, sub_cnt, txn_cnt;
  logic [31:0] ctl, dat, chk;
  logic        err_q;

  logic        is_bus, term, last_beat;
  logic [3:0]  len;
  logic [31:0] off_raw, off_lim, off;

  // Retry needs no action: the beat simply is not advanced without ack or err.
  logic unused_rty;
  assign unused_rty = wb_rty_i;

  // Tracing hook only; nothing is built from VERBOSE.
  if (VERBOSE) begin : g_verbose
  end

  assign is_bus    = (state == ST_WRITE) || (state == ST_READ);
  assign term      = is_bus && (wb_ack_i || wb_err_i);
  assign last_beat = (beat == len_m1);

  // Burst geometry from the control LFSR, clamped so the burst never leaves the window.
  assign len     = {1'b0, ctl[2:0]} + 4'd1;
  assign off_raw = (ctl >> 8) & (WORDS - 32'd1);
  assign off_lim = WORDS - {28'd0, len};
  assign off     = (off_raw > off_lim) ? off_lim : off_raw;

  lfsr32 #(.SEED(SEED)) u_ctl (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .en(state == ST_SETUP),
    .load(1'b0), .load_val(32'h0), .state(ctl)
  );

  lfsr32 #(.SEED(SEED)) u_dat (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .en((state == ST_WRITE) && term),
    .load(1'b0), .load_val(32'h0), .state(dat)
  );

  lfsr32 #(.SEED(SEED)) u_chk (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .en((state == ST_READ) && term),
    .load(state == ST_GAP), .load_val(dat_save), .state(chk)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= nstate;
  end

  // Next-state: IDLE waits one full cycle after reset so cyc rises on the third edge.
  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:  if (started) nstate = ST_SETUP;
      ST_SETUP: nstate = ST_WRITE;
      ST_WRITE: if (term && last_beat) nstate = ST_GAP;
      ST_GAP:   nstate = ST_READ;
      ST_READ:  if (term && last_beat) nstate = ST_NEXT;
      ST_NEXT:  nstate = ((sub_cnt == SUB_LAST) && (txn_cnt == TXN_LAST)) ? ST_DONE : ST_SETUP;
      ST_DONE:  nstate = ST_DONE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch geometry in SETUP, step the beat index on each termination.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      started  <= 1'b0;
      beat     <= 3'd0;
      len_m1   <= 3'd0;
      base     <= 32'h0;
      dat_save <= 32'h0;
      sub_cnt  <= 32'h0;
      txn_cnt  <= 32'h0;
    end else begin
      started <= 1'b1;
      if (state == ST_SETUP) begin
        len_m1   <= ctl[2:0];
        base     <= MEM_LOW + (off << 2);
        dat_save <= dat;
        beat     <= 3'd0;
      end else if (term) begin
        beat <= last_beat ? 3'd0 : beat + 3'd1;
      end
      if (state == ST_NEXT) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= 32'h0;
          txn_cnt <= txn_cnt + 32'd1;
        end else begin
          sub_cnt <= sub_cnt + 32'd1;
        end
      end
    end
  end

  // Sticky error: any bus error, or read data that differs from the replayed pattern.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) err_q <= 1'b0;
    else if ((is_bus && wb_err_i) ||
             ((state == ST_READ) && wb_ack_i && !wb_err_i && (wb_dat_i != chk)))
      err_q <= 1'b1;
  end

  // Bus outputs are decoded from registered state, so they hold during wait states
  // and move to the next beat on the same edge that samples ack.
  assign wb_cyc_o = is_bus;
  assign wb_stb_o = is_bus;
  assign wb_we_o  = (state == ST_WRITE);
  assign wb_adr_o = is_bus ? base + {27'd0, beat, 2'b00} : 32'h0;
  assign wb_dat_o = wb_we_o ? dat : 32'h0;
  assign wb_sel_o = is_bus ? 4'hF : 4'h0;
  assign wb_cti_o = is_bus ? (last_beat ? CTI_EOB : CTI_INC) : 3'b000;
  assign wb_bte_o = 2'b00;
  assign done     = (state == ST_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Bench: RAM slave with random waits and fault injection, checked against a burst-level model.
module tb_wb_traffic_gen;

  localparam logic [31:0] MEM_LOW  = 32'h0000_1000;
  localparam logic [31:0] MEM_HIGH = 32'h0000_103F;
  localparam int          WORDS    = 16;
  localparam int          TRANS    = 10;
  localparam int          SUBT     = 10;
  localparam int          NPAIRS   = TRANS * SUBT;
  localparam logic [31:0] SEED     = 32'h1234_5679;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam int          BUDGET   = 20000;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic        done, err;

  int n_checks = 0, n_errors = 0;

  beat_t       exp_q[$], log_q[$];
  logic [31:0] mem [int unsigned];
  int          len0;

  // Slave configuration and monitor results.
  int ack_wait_max, err_at, corrupt_at, rty_at;
  int cyc_n = 0, wr_idx, rd_idx, term_idx;
  int stab_bad, win_bad, proto_bad, gap_bad, rty_bad, rty_cycles;
  int last_rd_cyc, done_cyc, low_run, wait_left, rty_left;
  bit seen_cyc, new_beat, prev_act, prev_term, err_probe;
  logic        err_before, err_after;
  logic [67:0] prev_vec;
  logic [31:0] rty_adr, rty_dat;

  always #5 clk = ~clk;

  wb_traffic_gen #(
    .MEM_LOW(MEM_LOW), .MEM_HIGH(MEM_HIGH), .TRANSACTIONS(TRANS),
    .SUBTRANSACTIONS(SUBT), .SEED(SEED), .VERBOSE(1'b0)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .done(done), .err(err)
  );

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Expected beat stream: each pair is len writes of consecutive pattern words,
  // then len reads of the same addresses expecting the same words.
  task automatic build_model();
    logic [31:0] c, d, d2;
    int len, off;
    beat_t b;
    exp_q.delete();
    c = SEED;
    d = SEED;
    for (int p = 0; p < NPAIRS; p++) begin
      len = int'(c % 8) + 1;
      off = int'((c / 256) % WORDS);
      if (off > WORDS - len) off = WORDS - len;
      if (p == 0) len0 = len;
      d2 = d;
      for (int k = 0; k < len; k++) begin
        b.adr = MEM_LOW + 32'(4 * (off + k));
        b.we  = 1'b1;
        b.dat = d;
        b.cti = (k == len - 1) ? 3'b111 : 3'b010;
        exp_q.push_back(b);
        d = nxt(d);
      end
      for (int k = 0; k < len; k++) begin
        b.adr = MEM_LOW + 32'(4 * (off + k));
        b.we  = 1'b0;
        b.dat = d2;
        b.cti = (k == len - 1) ? 3'b111 : 3'b010;
        exp_q.push_back(b);
        d2 = nxt(d2);
      end
      c = nxt(c);
    end
  endtask

  function automatic int count_mism(input int n, input bit with_data);
    int m = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= log_q.size() || i >= exp_q.size()) m++;
      else if (log_q[i].adr !== exp_q[i].adr || log_q[i].we !== exp_q[i].we ||
               log_q[i].cti !== exp_q[i].cti ||
               (with_data && exp_q[i].we && log_q[i].dat !== exp_q[i].dat)) m++;
    end
    return m;
  endfunction

  // Slave plus protocol monitor, evaluated mid-cycle while master outputs are settled.
  initial begin
    beat_t b;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (err_probe) begin err_after = err; err_probe = 0; end
      if (done && done_cyc < 0) done_cyc = cyc_n;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0;
      if (!rst_n) begin
        new_beat = 1; prev_act = 0;
      end else if (wb_cyc_o) begin
        if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF || wb_bte_o !== 2'b00) proto_bad++;
        if (wb_adr_o < MEM_LOW || wb_adr_o > MEM_HIGH || wb_adr_o[1:0] != 2'b00) win_bad++;
        if (seen_cyc && low_run > 0 && low_run != (wb_we_o ? 2 : 1)) gap_bad++;
        seen_cyc = 1; low_run = 0;
        if (prev_act && !prev_term && {wb_adr_o, wb_dat_o, wb_we_o, wb_cti_o} !== prev_vec)
          stab_bad++;
        prev_vec = {wb_adr_o, wb_dat_o, wb_we_o, wb_cti_o};
        prev_act = 1; prev_term = 0;
        if (new_beat) begin
          wait_left = int'($urandom_range(0, ack_wait_max));
          rty_left  = (term_idx == rty_at) ? 2 : 0;
          new_beat  = 0;
        end
        if (wait_left > 0) wait_left--;
        else if (rty_left > 0) begin
          wb_rty_i = 1'b1; rty_left--; rty_cycles++;
          rty_adr = wb_adr_o; rty_dat = wb_dat_o;
        end else begin
          b.adr = wb_adr_o; b.we = wb_we_o; b.dat = wb_dat_o; b.cti = wb_cti_o;
          if (term_idx == rty_at && (rty_adr !== wb_adr_o || rty_dat !== wb_dat_o)) rty_bad++;
          if (wb_we_o && wr_idx == err_at) begin
            wb_err_i = 1'b1; err_before = err; err_probe = 1;
          end else begin
            wb_ack_i = 1'b1;
            if (wb_we_o) mem[wb_adr_o >> 2] = wb_dat_o;
            else begin
              rd = mem.exists(wb_adr_o >> 2) ? mem[wb_adr_o >> 2] : 32'h0;
              if (rd_idx == corrupt_at) begin
                rd[0] = ~rd[0]; err_before = err; err_probe = 1;
              end
              wb_dat_i = rd;
              last_rd_cyc = cyc_n;
            end
          end
          log_q.push_back(b);
          if (wb_we_o) wr_idx++; else rd_idx++;
          term_idx++; new_beat = 1; prev_term = 1;
        end
      end else begin
        prev_act = 0; new_beat = 1;
        if (seen_cyc) low_run++;
      end
    end
  end

  task automatic clear_state(input int wmax, input int e_at, input int c_at, input int r_at);
    ack_wait_max = wmax; err_at = e_at; corrupt_at = c_at; rty_at = r_at;
    wr_idx = 0; rd_idx = 0; term_idx = 0;
    stab_bad = 0; win_bad = 0; proto_bad = 0; gap_bad = 0; rty_bad = 0; rty_cycles = 0;
    last_rd_cyc = -1; done_cyc = -1; low_run = 0;
    seen_cyc = 0; new_beat = 1; prev_act = 0; prev_term = 0; err_probe = 0;
    err_before = 1'bx; err_after = 1'bx;
    log_q.delete(); mem.delete();
  endtask

  task automatic do_reset(input int wmax, input int e_at, input int c_at, input int r_at);
    @(negedge clk);
    rst_n = 1'b0;
    clear_state(wmax, e_at, c_at, r_at);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < BUDGET && !done; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_state(0, -1, -1, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o} !== 77'h0) begin
      n_errors++;
      $display("FAIL reset_outputs adr=%h dat=%h sel=%h we=%b cyc=%b cti=%b required all zero",
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_cti_o);
    end
    n_checks++;
    if ({done, err} !== 2'b00) begin
      n_errors++; $display("FAIL reset_flags done=%b err=%b required 0 0", done, err);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (wb_cyc_o !== (e == 3)) begin
        n_errors++; $display("FAIL startup_cyc edge=%0d cyc=%b required %b", e, wb_cyc_o, e == 3);
      end
    end
    n_checks++;
    if (wb_adr_o !== exp_q[0].adr || wb_we_o !== 1'b1 || wb_dat_o !== SEED || wb_cti_o !== exp_q[0].cti) begin
      n_errors++;
      $display("FAIL first_beat adr=%h we=%b dat=%h cti=%b required %h 1 %h %b",
               wb_adr_o, wb_we_o, wb_dat_o, wb_cti_o, exp_q[0].adr, SEED, exp_q[0].cti);
    end
  endtask

  task automatic test_zero_wait();
    int m;
    do_reset(0, -1, -1, -1);
    wait_done();
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_errors++; $display("FAIL zw_done done=%b err=%b required 1 0", done, err);
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL zw_beats got=%0d required %0d", log_q.size(), exp_q.size());
    end
    m = count_mism(exp_q.size(), 1'b1);
    n_checks++;
    if (m != 0) begin n_errors++; $display("FAIL zw_stream mismatched_beats=%0d required 0", m); end
    n_checks++;
    if (win_bad != 0 || proto_bad != 0) begin
      n_errors++; $display("FAIL zw_window out_of_window=%0d protocol=%0d required 0 0", win_bad, proto_bad);
    end
    n_checks++;
    if (gap_bad != 0) begin n_errors++; $display("FAIL zw_gaps bad_gaps=%0d required 0", gap_bad); end
    // Final ack sampled at edge E, done rises at E+1: seen two mid-cycle samples later.
    n_checks++;
    if (done_cyc - last_rd_cyc != 2) begin
      n_errors++; $display("FAIL zw_done_timing delta=%0d required 2", done_cyc - last_rd_cyc);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || wb_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL zw_done_sticky done=%b cyc=%b required 1 0", done, wb_cyc_o);
    end
  endtask

  task automatic test_wait_states();
    int m;
    do_reset(3, -1, -1, -1);
    wait_done();
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_errors++; $display("FAIL ws_done done=%b err=%b required 1 0", done, err);
    end
    n_checks++;
    if (stab_bad != 0) begin n_errors++; $display("FAIL ws_stable changes=%0d required 0", stab_bad); end
    m = count_mism(exp_q.size(), 1'b1);
    n_checks++;
    if (m != 0 || log_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL ws_stream mismatched_beats=%0d beats=%0d required 0 %0d", m, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_corrupt();
    do_reset(0, -1, int'($urandom_range(0, 50)), -1);
    wait_done();
    n_checks++;
    if (err_before !== 1'b0 || err_after !== 1'b1) begin
      n_errors++; $display("FAIL corrupt_edge before=%b after=%b required 0 1", err_before, err_after);
    end
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_errors++; $display("FAIL corrupt_done done=%b err=%b required 1 1", done, err);
    end
  endtask

  task automatic test_bus_err();
    int m;
    do_reset(1, int'($urandom_range(0, 50)), -1, -1);
    wait_done();
    n_checks++;
    if (err_before !== 1'b0 || err_after !== 1'b1) begin
      n_errors++; $display("FAIL buserr_edge before=%b after=%b required 0 1", err_before, err_after);
    end
    m = count_mism(exp_q.size(), 1'b0);
    n_checks++;
    if (done !== 1'b1 || m != 0 || log_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL buserr_advance done=%b bad_addr=%0d beats=%0d required 1 0 %0d",
                           done, m, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_retry();
    int m;
    do_reset(1, -1, -1, int'($urandom_range(0, 300)));
    wait_done();
    n_checks++;
    if (rty_cycles != 2 || rty_bad != 0) begin
      n_errors++; $display("FAIL retry_hold rty_cycles=%0d changed=%0d required 2 0", rty_cycles, rty_bad);
    end
    m = count_mism(exp_q.size(), 1'b1);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || m != 0) begin
      n_errors++; $display("FAIL retry_stream done=%b err=%b bad=%0d required 1 0 0", done, err, m);
    end
  endtask

  task automatic test_reset_mid_read();
    int m;
    do_reset(0, -1, -1, -1);
    for (int i = 0; i < 2000 && !(rd_idx >= 5 && wb_cyc_o && !wb_we_o); i++) @(negedge clk);
    n_checks++;
    if (!(wb_cyc_o === 1'b1 && wb_we_o === 1'b0)) begin
      n_errors++; $display("FAIL midrd_reach cyc=%b we=%b required 1 0", wb_cyc_o, wb_we_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_errors++; $display("FAIL midrd_async cyc=%b stb=%b required 0 0", wb_cyc_o, wb_stb_o);
    end
    do_reset(0, -1, -1, -1);
    for (int i = 0; i < 50 && log_q.size() < len0; i++) @(negedge clk);
    m = count_mism(len0, 1'b1);
    n_checks++;
    if (m != 0) begin
      n_errors++; $display("FAIL midrd_first_burst bad=%0d of %0d required 0", m, len0);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_corrupt();
    test_bus_err();
    test_retry();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
